// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the data-memory access stage and the control unit.
package load_store_unit_pkg;

  // funct3 access size / sign encodings
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Opcodes shared with the control unit
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_t;

  // Conflicting direction, unknown size code, or address not aligned to the access size
  function automatic logic lsu_fault(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] addr_lo);
    logic illegal;
    logic unaligned;
    illegal   = (rd && wr)
             || (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
             || (wr && (f3 > LSU_W));
    unaligned = (f3[1:0] == 2'b01 && addr_lo[0])
             || (f3[1:0] == 2'b10 && addr_lo != 2'b00);
    return illegal || unaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: store data replication / byte strobes and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the read word
  always_comb begin
    sel_byte = rdata[7:0];
    case (addr_lo)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size-dependent steering for both directions
  always_comb begin
    wdata    = '0;
    wstrb    = '0;
    load_ext = '0;
    case (funct3)
      LSU_B: begin
        wdata    = {4{rs2_data[7:0]}};
        wstrb    = 4'b0001 << addr_lo;
        load_ext = {{24{sel_byte[7]}}, sel_byte};
      end
      LSU_H: begin
        wdata    = {2{rs2_data[15:0]}};
        wstrb    = 4'b0011 << addr_lo;
        load_ext = {{16{sel_half[15]}}, sel_half};
      end
      LSU_W: begin
        wdata    = rs2_data;
        wstrb    = 4'b1111;
        load_ext = rdata;
      end
      LSU_BU:  load_ext = {24'b0, sel_byte};
      LSU_HU:  load_ext = {16'b0, sel_half};
      default: load_ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one req/ready bus transaction per
// load/store, stalls the core meanwhile, reports faults and bus timeouts.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            misaligned,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic        req;
  logic        fault;
  logic        can_issue;
  logic        expire;
  logic [1:0]  al_addr_lo;
  logic [2:0]  al_f3;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic [31:0] al_load;

  assign req   = MemRead | MemWrite;
  assign fault = lsu_fault(MemRead, MemWrite, funct3, alu_result[1:0]);

  // The cycle carrying bus_err still presents the timed-out instruction;
  // blocking issue there keeps it from being retried as a new request.
  assign can_issue  = !rst && (state == IDLE) && !bus_err;
  assign stall      = (state == BUSY) || (can_issue && req && !fault);
  assign misaligned = can_issue && req && fault;
  assign expire     = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  // Live instruction fields while idle, latched ones once the bus is busy
  always_comb begin
    al_addr_lo = (state == IDLE) ? alu_result[1:0] : addr_lo_q;
    al_f3      = (state == IDLE) ? funct3 : f3_q;
  end

  lsu_align u_align (
    .addr_lo  (al_addr_lo),
    .funct3   (al_f3),
    .rs2_data (rs2_data),
    .rdata    (mem_rdata),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .load_ext (al_load)
  );

  // Transaction FSM with registered bus signals and completion strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_lo_q  <= '0;
      f3_q       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (can_issue && req && !fault) begin
            addr_lo_q <= alu_result[1:0];
            f3_q      <= funct3;
            mem_we    <= MemWrite;
            mem_addr  <= {alu_result[XLEN-1:2], 2'b00};
            mem_wstrb <= MemWrite ? al_wstrb : 4'b0000;
            mem_wdata <= al_wdata;
            mem_req   <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              load_valid <= 1'b1;
              load_data  <= al_load;
            end
            state <= DONE;
          end else if (expire) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
